// File: rtl/uart_rx_if.sv
// uart_rx_if: serial-side and byte-side signals of the UART receiver.
// The slave modport is the receiver's view; the master modport drives rx and s_tick.
`timescale 1ns/1ps
interface uart_rx_if #(
  parameter int unsigned DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic            rx_done_tick;
  logic [DBIT-1:0] dout;
  logic            frame_err;
  logic            parity_err;

  modport master (
    output rx,
    output s_tick,
    input  rx_done_tick,
    input  dout,
    input  frame_err,
    input  parity_err
  );

  modport slave (
    input  rx,
    input  s_tick,
    output rx_done_tick,
    output dout,
    output frame_err,
    output parity_err
  );
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver (start, DBIT data LSB-first, [parity], stop).
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data
// and drives parity_err; without it parity_err is tied low.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic      clk,
  input  logic      reset,
  uart_rx_if.slave  bus
);

  // s_cnt must reach 15 for data bits and SB_TICK-1 in the stop bit
  localparam int unsigned SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int unsigned NW = 3;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state_q, state_d;
  logic [SW-1:0]   s_cnt_q, s_cnt_d;
  logic [NW-1:0]   n_cnt_q, n_cnt_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_meta_q, rx_s_q;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d;
  logic            perr_q, perr_d;
`endif

  // Two-flop synchronizer for the asynchronous serial line; idles high
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= bus.rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q   <= par_d;
      perr_q  <= perr_d;
`endif
    end
  end

  // Next-state logic: counters only advance on s_tick, using the current state
  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = ferr_q;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = perr_q;
`endif

    case (state_q)
      IDLE: begin
        // A low line starts a frame without waiting for a tick
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end

      START: begin
        if (bus.s_tick) begin
          if (s_cnt_q == SW'(7)) begin
            // Mid start bit: a high line here was a glitch
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      DATA: begin
        if (bus.s_tick) begin
          if (s_cnt_q == SW'(15)) begin
            shreg_d = {rx_s_q, shreg_q[DBIT-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == NW'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              n_cnt_d = n_cnt_q + NW'(1);
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (bus.s_tick) begin
          if (s_cnt_q == SW'(15)) begin
            par_d   = rx_s_q;
            s_cnt_d = '0;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
`endif

      STOP: begin
        if (bus.s_tick) begin
          if (s_cnt_q == SW'(SB_TICK - 1)) begin
            // Frame complete even on a bad stop bit; frame_err flags it
            dout_d  = shreg_q;
            ferr_d  = ~rx_s_q;
            done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = (^shreg_q) ^ par_q;
`endif
            state_d = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_done_tick = done_q;
  assign bus.dout         = dout_q;
  assign bus.frame_err    = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err   = perr_q;
`else
  assign bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives serial frames bit by bit and compares each received byte
// against a queue of expected results derived from the transmitted frame.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned DBIT    = 8;
  localparam int          BIT_CLK = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_rx_if #(.DBIT(DBIT)) bus ();

  uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // baud_gen stand-in with dvsr=3: one s_tick every 4 clk
  logic [1:0] tdiv;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tdiv       <= 2'd0;
      bus.s_tick <= 1'b0;
    end else begin
      tdiv       <= tdiv + 2'd1;
      bus.s_tick <= (tdiv == 2'd2);
    end
  end

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   pulses = 0;
  int   last_done_cyc = 0;
  int   t_start = 0;
  int   snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding frame
  always @(negedge clk) begin
    if (reset === 1'b1 && bus.rx_done_tick === 1'b1) begin
      pulses++;
      last_done_cyc = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dout", 32'(bus.dout), 32'(mon_e.d));
        chk("frame_err", 32'(bus.frame_err), 32'(mon_e.fe));
        chk("parity_err", 32'(bus.parity_err), 32'(mon_e.pe));
      end
    end
  end

  task automatic hold(input logic v, input int n);
    bus.rx = v;
    repeat (n) @(negedge clk);
  endtask

  // One frame; a bad stop bit is low for 3/4 of the bit so the line is
  // unambiguously high again when the receiver re-checks for a start bit.
  task automatic send_frame(input logic [7:0] d, input logic stop_ok,
                            input logic par_ok, input int gap_bits);
    exp_t e;
    int   gap;
    e.d  = d;
    e.fe = ~stop_ok;
`ifdef UART_RX_PARITY_EN
    e.pe = ~par_ok;
`else
    e.pe = 1'b0;
`endif
    exp_q.push_back(e);
    gap = gap_bits;
    t_start = cyc;
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    hold((^d) ^ ~par_ok, BIT_CLK);
`endif
    if (stop_ok) begin
      hold(1'b1, BIT_CLK);
    end else begin
      hold(1'b0, 48);
      hold(1'b1, BIT_CLK - 48);
      if (gap < 1) gap = 1;
    end
    if (gap > 0) hold(1'b1, gap * BIT_CLK);
  endtask

  initial begin
    bus.rx = 1'b1;
    reset  = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_done", 32'(bus.rx_done_tick), 32'd0);
    chk("rst_dout", 32'(bus.dout), 32'd0);
    chk("rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("rst_perr", 32'(bus.parity_err), 32'd0);
    reset = 1'b1;

    hold(1'b1, 500);
    chk("idle_pulses", 32'(pulses), 32'd0);

    send_frame(8'hA5, 1'b1, 1'b1, 2);
    chk("a5_pulses", 32'(pulses), 32'd1);
    chk("a5_latency", 32'((last_done_cyc - t_start) >= 560 && (last_done_cyc - t_start) <= 680), 32'd1);

    send_frame(8'h00, 1'b1, 1'b1, 0);
    send_frame(8'hFF, 1'b1, 1'b1, 2);
    chk("b2b_pulses", 32'(pulses), 32'd3);

    hold(1'b0, 12);
    hold(1'b1, 200);
    chk("glitch_pulses", 32'(pulses), 32'd3);

    send_frame(8'h3C, 1'b0, 1'b1, 2);
    chk("ferr_pulses", 32'(pulses), 32'd4);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1);
    send_frame(8'h07, 1'b1, 1'b0, 1);
`endif

    for (int k = 0; k < 20; k++) begin
      send_frame(8'($urandom), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) != 0), $urandom_range(0, 2));
    end
    hold(1'b1, 200);

    // Reset in the middle of a frame discards it
    snap = pulses;
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK);
    hold(1'b0, 40);
    reset  = 1'b0;
    bus.rx = 1'b1;
    repeat (10) @(negedge clk);
    chk("midrst_dout", 32'(bus.dout), 32'd0);
    chk("midrst_ferr", 32'(bus.frame_err), 32'd0);
    reset = 1'b1;
    hold(1'b1, 800);
    chk("midrst_pulses", 32'(pulses), 32'(snap));
    send_frame(8'h5A, 1'b1, 1'b1, 2);
    chk("post_rst_pulses", 32'(pulses), 32'(snap + 1));

    hold(1'b1, 200);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
